// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter.
// Master ids, arbitration modes and the request bundle.
package mem_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 16;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wrdata;
    logic                  rd;
    logic                  wr;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on last grant or fixed
// priority to master 0. Grant is combinational and one-hot.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t last_grant_i,
  input  logic       fixed_i,
  output logic [1:0] grant_o
);

  // Pick a winner among the active requests
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        if (fixed_i)
          grant_o = 2'b01;
        else if (last_grant_i == M0)
          grant_o = 2'b10;
        else
          grant_o = 2'b01;
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between CPU (m0) and DMA (m1).
// Registers the winning command, routes read data back by tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_rd,
  input  logic              i_m0_wr,
  input  logic [DATA_W-1:0] i_m0_wrdata,
  output logic              o_m0_waitrequest,
  output logic [DATA_W-1:0] o_m0_rddata,
  output logic              o_m0_rdvalid,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_rd,
  input  logic              i_m1_wr,
  input  logic [DATA_W-1:0] i_m1_wrdata,
  output logic              o_m1_waitrequest,
  output logic [DATA_W-1:0] o_m1_rddata,
  output logic              o_m1_rdvalid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata
);

  localparam logic FIXED = (ARB_MODE == ARB_FIXED);

  mem_req_t   r0, r1, sel;
  logic [1:0] req;
  logic [1:0] grant_raw;
  logic [1:0] grant;
  logic       acc;
  master_id_t win;

  master_id_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              v1_q, v1_d;
  master_id_t        tag1_q, tag1_d;
  logic              v2_q, v2_d;
  master_id_t        tag2_q, tag2_d;

  // Bundle each master's request
  always_comb begin
    r0        = '0;
    r0.addr   = REQ_ADDR_W'(i_m0_addr);
    r0.wrdata = REQ_DATA_W'(i_m0_wrdata);
    r0.rd     = i_m0_rd;
    r0.wr     = i_m0_wr;
    r1        = '0;
    r1.addr   = REQ_ADDR_W'(i_m1_addr);
    r1.wrdata = REQ_DATA_W'(i_m1_wrdata);
    r1.rd     = i_m1_rd;
    r1.wr     = i_m1_wr;
  end

  assign req = {r1.rd | r1.wr, r0.rd | r0.wr};

  rr_arb2 u_arb (
    .req_i        (req),
    .last_grant_i (last_q),
    .fixed_i      (FIXED),
    .grant_o      (grant_raw)
  );

  // Nothing is accepted while reset is held
  assign grant = grant_raw & {2{~reset}};
  assign acc   = |grant;
  assign win   = grant[1] ? M1 : M0;
  assign sel   = grant[1] ? r1 : r0;

  assign o_m0_waitrequest = req[0] & ~grant[0];
  assign o_m1_waitrequest = req[1] & ~grant[1];

  // Next-state: command register, last grant, read pipeline
  always_comb begin
    last_d = acc ? win : last_q;
    addr_d = acc ? ADDR_W'(sel.addr) : addr_q;
    wdat_d = acc ? DATA_W'(sel.wrdata) : wdat_q;
    wr_d   = acc & sel.wr;
    rd_d   = acc & sel.rd & ~sel.wr;
    v1_d   = rd_d;
    tag1_d = win;
    v2_d   = v1_q;
    tag2_d = tag1_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= M1;
      addr_q <= '0;
      wdat_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      v1_q   <= 1'b0;
      tag1_q <= M0;
      v2_q   <= 1'b0;
      tag2_q <= M0;
    end else begin
      last_q <= last_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      v1_q   <= v1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      tag2_q <= tag2_d;
    end
  end

  assign o_mem_addr   = addr_q;
  assign o_mem_wrdata = wdat_q;
  assign o_mem_rd     = rd_q;
  assign o_mem_wr     = wr_q;

  assign o_m0_rddata  = i_mem_rddata;
  assign o_m1_rddata  = i_mem_rddata;
  assign o_m0_rdvalid = v2_q & (tag2_q == M0);
  assign o_m1_rdvalid = v2_q & (tag2_q == M1);

endmodule
